// File: rtl/truth_table_extractor.sv
// rtl/truth_table_extractor.sv - sweeps a 3-input DUT and assembles its 8-bit truth-table code
module truth_table_extractor #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic [2:0] dut_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic [7:0] unstable,
    output logic       match
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES - 1);

    state_t     state, state_nxt;
    logic [7:0] scnt;
    logic [3:0] ncnt;
    logic [2:0] vec;
    logic [7:0] exp_q;
    logic [7:0] sh_code, sh_unst;
    logic [7:0] cur_code, cur_unst;
    logic       first_q;
    logic       settle_end, sample_end, sweep_end;

    assign settle_end = (scnt == SETTLE_LAST);
    assign sample_end = (ncnt == SAMPLE_LAST);
    assign sweep_end  = (state == SAMPLE) && sample_end && (vec == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (abort) state_nxt = IDLE;
                     else if (settle_end) state_nxt = SAMPLE;
            SAMPLE:  if (abort) state_nxt = IDLE;
                     else if (sample_end) state_nxt = (vec == 3'd7) ? IDLE : SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        dut_in = busy ? vec : 3'd0;
    end

    // Shadow registers with this edge's sample folded in; vector i lands on bit 7-i.
    always_comb begin
        cur_code = sh_code;
        cur_unst = sh_unst;
        if (ncnt == 4'd0)
            cur_code[~vec] = dut_out;
        else if (dut_out != first_q)
            cur_unst[~vec] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt     <= 8'd0;
            ncnt     <= 4'd0;
            vec      <= 3'd0;
            exp_q    <= 8'd0;
            sh_code  <= 8'd0;
            sh_unst  <= 8'd0;
            first_q  <= 1'b0;
            done     <= 1'b0;
            code     <= 8'd0;
            unstable <= 8'd0;
            match    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    exp_q   <= expected;
                    sh_code <= 8'd0;
                    sh_unst <= 8'd0;
                    vec     <= 3'd0;
                    scnt    <= 8'd0;
                    ncnt    <= 4'd0;
                end
                SETTLE: if (!abort) begin
                    scnt <= settle_end ? 8'd0 : scnt + 8'd1;
                    ncnt <= 4'd0;
                end
                SAMPLE: if (!abort) begin
                    sh_code <= cur_code;
                    sh_unst <= cur_unst;
                    if (ncnt == 4'd0) first_q <= dut_out;
                    ncnt <= sample_end ? 4'd0 : ncnt + 4'd1;
                    if (sample_end && vec != 3'd7) vec <= vec + 3'd1;
                end
                default: ;
            endcase
            if (sweep_end && !abort) begin
                done     <= 1'b1;
                code     <= cur_code;
                unstable <= cur_unst;
                match    <= (cur_code == exp_q) && (cur_unst == 8'd0);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_extractor.sv
// tb/tb_truth_table_extractor.sv - directed self-checking bench for truth_table_extractor
module tb_truth_table_extractor;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, dut_out;
    logic [7:0] expected;
    logic [2:0] dut_in;
    logic       busy, done, match;
    logic [7:0] code, unstable;

    logic [7:0] model_code;
    logic       glitch;
    logic [16:0] sb[$];
    logic [7:0] last_code, last_unst;
    logic       last_match;
    int         n_asserts = 0;
    int         n_fails   = 0;

    truth_table_extractor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .done(done), .code(code), .unstable(unstable), .match(match)
    );

    always #5 clk = ~clk;

    // Behavioural DUT: input pattern i reads code bit 7-i; glitch pulls the output low.
    assign dut_out = glitch ? 1'b0 : model_code[3'd7 - dut_in];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_dut_in"}, {5'd0, dut_in}, 8'd0);
        chk({tag, "_code"}, code, 8'd0);
        chk({tag, "_unstable"}, unstable, 8'd0);
        chk({tag, "_match"}, {7'd0, match}, 8'd0);
    endtask

    // One sweep from start acceptance; abort_at/glitch_at/pulse_at are edge numbers after E0 (0 = unused).
    task automatic sweep(input string tag, input logic [7:0] fcode, input logic [7:0] exp_code,
                         input logic [7:0] exp_unst, input int glitch_at, input int abort_at,
                         input int pulse_at, input bit hold_start);
        logic [7:0] cur_dut_in;
        model_code = fcode;
        expected   = exp_code;
        start      = 1'b1;
        step();
        start      = 1'b0;
        expected   = ~exp_code;
        chk({tag, "_e0_busy"}, {7'd0, busy}, 8'd1);
        chk({tag, "_e0_dut_in"}, {5'd0, dut_in}, 8'd0);
        if (abort_at == 0)
            sb.push_back({fcode, exp_unst, (fcode == exp_code) && (exp_unst == 8'd0)});
        for (int k = 1; k <= 56; k++) begin
            start  = (k == pulse_at) || (hold_start && k >= 56);
            glitch = (k == glitch_at);
            abort  = (k == abort_at);
            step();
            glitch = 1'b0;
            abort  = 1'b0;
            if (k == abort_at) begin
                chk({tag, "_abort_busy"}, {7'd0, busy}, 8'd0);
                chk({tag, "_abort_dut_in"}, {5'd0, dut_in}, 8'd0);
                chk({tag, "_abort_code"}, code, last_code);
                chk({tag, "_abort_unstable"}, unstable, last_unst);
                chk({tag, "_abort_match"}, {7'd0, match}, {7'd0, last_match});
                for (int j = 0; j < 60; j++) begin
                    step();
                    chk({tag, "_abort_no_done"}, {7'd0, done}, 8'd0);
                end
                return;
            end
            cur_dut_in = (k < 56) ? 8'(k / 7) : 8'd0;
            chk({tag, "_dut_in"}, {5'd0, dut_in}, cur_dut_in);
            chk({tag, "_busy"}, {7'd0, busy}, (k < 56) ? 8'd1 : 8'd0);
            chk({tag, "_done"}, {7'd0, done}, (k == 56) ? 8'd1 : 8'd0);
        end
        if (sb.size() == 0) begin
            n_asserts++;
            n_fails++;
            $error("FAIL %s_scoreboard: observed empty expected entry", tag);
        end else begin
            logic [16:0] e;
            e = sb.pop_front();
            chk({tag, "_code"}, code, e[16:9]);
            chk({tag, "_unstable"}, unstable, e[8:1]);
            chk({tag, "_match"}, {7'd0, match}, {7'd0, e[0]});
            last_code  = e[16:9];
            last_unst  = e[8:1];
            last_match = e[0];
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        glitch     = 1'b0;
        expected   = 8'h00;
        model_code = 8'hA4;
        last_code  = 8'h00;
        last_unst  = 8'h00;
        last_match = 1'b0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        sweep("nominal", 8'hA4, 8'hA4, 8'h00, 0, 0, 0, 1'b0);
        sweep("mismatch", 8'hA4, 8'h5B, 8'h00, 0, 0, 0, 1'b0);
        sweep("abort", 8'hA4, 8'hA4, 8'h00, 0, 20, 0, 1'b0);
        sweep("glitch", 8'hFF, 8'hFF, 8'h04, 41, 0, 0, 1'b0);
        step();
        sweep("start_ignored", 8'hA4, 8'hA4, 8'h00, 0, 0, 10, 1'b1);
        sweep("back_to_back", 8'h3C, 8'h3C, 8'h00, 0, 0, 0, 1'b0);

        // Asynchronous reset between edges 30 and 31 of a sweep.
        model_code = 8'hA4;
        expected   = 8'hA4;
        start      = 1'b1;
        step();
        start      = 1'b0;
        repeat (30) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        #1;
        rst_n      = 1'b1;
        last_code  = 8'h00;
        last_unst  = 8'h00;
        last_match = 1'b0;
        sweep("after_reset", 8'hA4, 8'hA4, 8'h00, 0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/truth_table_extractor.md
# truth_table_extractor

Sequential characterizer that drives all eight input combinations into a 3-input combinational logic module and assembles its response into the 8-bit Wolfram-style truth-table code, e.g. 0xA4. It is the inverse of the per-code logic modules: those map a code to a function, and this block measures a function and produces its code. Each vector is held for a settle window and then sampled repeatedly, so slow or glitchy outputs are flagged. The block sits in the characterization bench next to the device under test (DUT) and compares the result against an expected code.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles each vector is held before sampling begins. Legal range is 1 to 255.
- SAMPLES, default 3: consecutive samples taken per vector. Legal range is 1 to 15.

Ports:
- clk, input, 1: the single clock. All logic is rising-edge triggered.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a sweep. Accepted only in IDLE.
- abort, input, 1: synchronous sweep abort.
- expected, input, 8: reference code. Latched when start is accepted.
- dut_out, input, 1: DUT output (the `out` of the DUT).
- dut_in, output, 3: DUT inputs packed as {in1, in2, in3}.
- busy, output, 1: high while a sweep is running.
- done, output, 1: one-cycle pulse when a sweep completes.
- code, output, 8: measured truth-table code.
- unstable, output, 8: per-bit flag set when the samples for that vector disagreed.
- match, output, 1: high when code equals the latched expected value and unstable is 0x00.

## Operation
Code bit mapping:
- For dut_in = i (i = 0 to 7), the measured value is written to code bit (7−i).
- The same mapping applies to unstable.
- Example: a function giving 1 for 000, 010 and 101 (0 elsewhere) measures as code 0xA4.

States:
- IDLE: busy = 0 and dut_in = 000.
  - start = 1 at an edge latches expected, clears the shadow code and unstable registers, sets vec = 0, and moves to SETTLE.
- SETTLE: dut_in = vec.
  - Counts SETTLE_CYCLES edges, then moves to SAMPLE.
- SAMPLE: captures dut_out at each of SAMPLES edges.
  - The first sample is recorded as the vector's value.
  - Any later sample that differs from the first sets that vector's unstable shadow bit.
  - After the last sample, if vec < 7: vec increments and the state returns to SETTLE.
  - If vec = 7: the shadow registers are copied to code and unstable, match is computed, done pulses, and the state returns to IDLE.

Control rules:
- start is ignored while busy.
- abort in SETTLE or SAMPLE returns to IDLE on that edge:
  - no done pulse;
  - code, unstable and match keep their previous values;
  - dut_in returns to 000.
- abort has priority over an internal state advance on the same edge.
- abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.

Result registers:
- code, unstable and match update only on the done edge and are held until the next completed sweep.
- Partial results are never visible on these outputs.

## Timing
Reset values while rst_n = 0 (takes effect immediately, without waiting for a clock edge):
- state = IDLE, busy = 0, done = 0, dut_in = 000, code = 0x00, unstable = 0x00, match = 0.
- Reset mid-sweep aborts the sweep and clears all outputs to these values.

Sweep timing:
- Call the edge that accepts start E0.
- After E0: busy = 1 and dut_in = 000.
- Vector v is driven from edge E(v·(S+N)) to edge E((v+1)·(S+N)), where S = SETTLE_CYCLES and N = SAMPLES.
- Vector v is sampled at edges v·(S+N)+S+1 through (v+1)·(S+N).
- After edge 8·(S+N): done = 1, busy = 0, and the results are valid. With the defaults this is edge 56.
- done stays high for exactly one cycle.

Back-to-back sweeps:
- start held high during the done cycle is accepted at the next edge.
- This gives no idle gap beyond the done cycle.

Width rules:
- The settle counter is 8 bits and the sample counter is 4 bits.
- vec is 3 bits and never wraps mid-sweep.

## Test plan
- **Nominal match:** DUT model implements code 0xA4, expected = 0xA4, defaults, start pulse at E0.
  - Required: dut_in steps 0 to 7 every 7 cycles; done at edge 56; code = 0xA4, unstable = 0x00, match = 1.
- **Mismatch:** same DUT, expected = 0x5B.
  - Required: code = 0xA4, match = 0.
- **Glitch detection:** DUT model implements code 0xFF, but dut_out is forced to 0 for one cycle during the second sample of vector 5.
  - Required: code = 0xFF, unstable = 0x04, match = 0.
- **Abort:** complete one sweep giving code 0xA4, then start a second sweep and assert abort at edge 20.
  - Required: busy = 0 after that edge; no done pulse; code stays 0xA4; dut_in = 000.
- **Reset mid-sweep:** assert rst_n = 0 asynchronously between edges 30 and 31.
  - Required: all outputs are immediately at their reset values.
  - After release, a start runs a full sweep with done at 56 edges after acceptance.
- **Start handling:** a start pulse at edge 10 (busy) is ignored, so done still arrives at edge 56. Then hold start high through the done cycle.
  - Required: a second sweep begins at edge 57, with done at edge 113.
